i2s_tx: RTL and testbench

Downstream neighbour of the delay effect. Consumes the 16-bit mono sample on the delay output and serialises it to an external audio DAC as a standard I2S stream. The same sample goes into both left and right slots. A one-clock `sample_stb` marks each frame start and sets the audio sample rate for the upstream chain. Runs on the 50 MHz system clock and generates BCLK/LRCLK internally, so the DAC is clock slave.

---
 rtl/theremin_audio_pkg.sv | 18 +
 rtl/i2s_bclk_gen.sv | 41 ++++
 rtl/i2s_tx.sv | 122 ++++++++++++
 tb/tb_i2s_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/theremin_audio_pkg.sv
// Shared definitions for the theremin audio chain: sample width, I2S
// transmitter state encoding and frame-length helper.
package theremin_audio_pkg;

  localparam int SIG_BITS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } i2s_state_t;

  // System clocks per stereo frame: two slots of slot_b bit clocks.
  function automatic int frame_clks(input int bclk_div, input int slot_b);
    return 4 * bclk_div * slot_b;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider for the I2S transmitter: divides clk by 2*BCLK_DIV and
// flags the clk on which bclk is about to rise or fall.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clr,
  output logic bclk,
  output logic rise,
  output logic fall
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  // Strobes are valid on the clk whose edge performs the toggle.
  assign wrap = run && !clr && (div_cnt == DIV_LAST);
  assign rise = wrap && !bclk;
  assign fall = wrap && bclk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (clr || !run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: sends one mono sample in both slots of every frame,
// generating bclk/lrclk locally; a stop request always completes the frame.
//
// state | meaning
// IDLE  | outputs parked at 0, waiting for enable
// RUN   | streaming frames, new sample latched at every frame start
// STOP  | enable dropped; finishing current frame, then back to IDLE
module i2s_tx
  import theremin_audio_pkg::*;
#(
  parameter int SIG_BITS = SIG_BITS_DEF,
  parameter int BCLK_DIV = 8,
  parameter int SLOT_B   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SIG_BITS-1:0] in,
  input  logic                enable,
  output logic                sample_stb,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                busy
);

  localparam int BW = $clog2(2 * SLOT_B);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_B - 1);
  localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_B);
  localparam logic [BW-1:0] SIG_W    = BW'(SIG_BITS);

  i2s_state_t          state;
  logic [BW-1:0]       bit_cnt;
  logic [BW-1:0]       bit_nxt;
  logic [BW-1:0]       k_nxt;
  logic [SIG_BITS-1:0] hold;
  logic [SIG_BITS-1:0] hold_sh;
  logic                lr_nxt;
  logic                sd_nxt;
  logic                run_entry;
  logic                gen_run;
  logic                bclk_fall;
  logic                bclk_rise_unused;

  assign run_entry = (state == IDLE) && enable;
  assign gen_run   = (state != IDLE);

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (gen_run),
    .clr    (run_entry),
    .bclk   (bclk),
    .rise   (bclk_rise_unused),
    .fall   (bclk_fall)
  );

  // Values lrclk/sdata take once bit_cnt advances on this fall event.
  always_comb begin
    bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    lr_nxt  = (bit_nxt >= SLOT_W);
    k_nxt   = lr_nxt ? (bit_nxt - SLOT_W) : bit_nxt;
    hold_sh = hold << (k_nxt - 1'b1);
    sd_nxt  = 1'b0;
    if ((k_nxt != '0) && (k_nxt <= SIG_W)) begin
      sd_nxt = hold_sh[SIG_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      hold       <= '0;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state      <= RUN;
            busy       <= 1'b1;
            bit_cnt    <= '0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            hold       <= in;
            sample_stb <= 1'b1;
          end
        end
        RUN, STOP: begin
          if ((state == STOP) && !enable && bclk_fall && (bit_cnt == BIT_LAST)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bit_cnt <= '0;
            lrclk   <= 1'b0;
            sdata   <= 1'b0;
          end else begin
            state <= enable ? RUN : STOP;
            if (bclk_fall) begin
              bit_cnt <= bit_nxt;
              lrclk   <= lr_nxt;
              sdata   <= sd_nxt;
              if (bit_cnt == BIT_LAST) begin
                hold       <= in;
                sample_stb <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: default instance plus a short-frame instance, both
// compared every clk against a frame-time arithmetic reference.
module tb_i2s_tx;

  localparam int SIG = 16;

  logic           clk     = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable  = 1'b0;
  logic [SIG-1:0] din     = '0;

  logic stb0, bclk0, lr0, sd0, busy0;
  logic stb1, bclk1, lr1, sd1, busy1;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  i2s_tx #(.SIG_BITS(SIG), .BCLK_DIV(8), .SLOT_B(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .in(din), .enable(enable),
    .sample_stb(stb0), .bclk(bclk0), .lrclk(lr0), .sdata(sd0), .busy(busy0)
  );

  i2s_tx #(.SIG_BITS(SIG), .BCLK_DIV(2), .SLOT_B(17)) dut1 (
    .clk(clk), .reset_n(reset_n), .in(din), .enable(enable),
    .sample_stb(stb1), .bclk(bclk1), .lrclk(lr1), .sdata(sd1), .busy(busy1)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: per instance, clks elapsed since the frame start and the word
  // captured there; every output follows from that by plain arithmetic.
  int             dv[2] = '{8, 2};
  int             sl[2] = '{32, 17};
  bit             act[2] = '{1'b0, 1'b0};
  int             n[2]   = '{0, 0};
  logic [SIG-1:0] w[2];

  function automatic int flen(input int d);
    return 4 * dv[d] * sl[d];
  endfunction

  function automatic logic [4:0] expect_vec(input int d);
    int             pos, k;
    logic [SIG-1:0] sh;
    logic           sd;
    if (!act[d]) return 5'b0;
    pos = n[d] / (2 * dv[d]);
    k   = pos % sl[d];
    sd  = 1'b0;
    if (k >= 1 && k <= SIG) begin
      sh = w[d] >> (SIG - k);
      sd = sh[0];
    end
    return {n[d] == 0, ((n[d] / dv[d]) % 2) == 1, pos >= sl[d], sd, 1'b1};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act[0] = 1'b0;
      act[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!act[d]) begin
          if (enable) begin
            act[d] = 1'b1;
            n[d]   = 0;
            w[d]   = din;
          end
        end else begin
          n[d]++;
          if (n[d] == flen(d)) begin
            if (!enable) act[d] = 1'b0;
            else begin
              n[d] = 0;
              w[d] = din;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("wave0", {27'd0, stb0, bclk0, lr0, sd0, busy0}, {27'd0, expect_vec(0)});
    chk("wave1", {27'd0, stb1, bclk1, lr1, sd1, busy1}, {27'd0, expect_vec(1)});
  end

  // Event timestamps, taken just after the clk edge.
  int   stb_t0[$];
  int   stb_t1[$];
  int   brise0[$];
  logic bclk0_q = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (stb0) stb_t0.push_back(cyc);
    if (stb1) stb_t1.push_back(cyc);
    if (bclk0 && !bclk0_q) brise0.push_back(cyc);
    bclk0_q = bclk0;
  end

  // I2S receiver on dut0: slot position counted from each lrclk change.
  bit          rx_on     = 1'b0;
  int          rx_pos    = -1;
  logic        rx_lr     = 1'b0;
  logic [15:0] rx_sh     = '0;
  logic [16:0] rx_q[$];
  int          rx_tail   = 0;
  int          slot_len[$];

  always @(posedge bclk0) begin
    if (rx_on) begin
      if (lr0 != rx_lr) begin
        slot_len.push_back(rx_pos + 1);
        rx_pos = 0;
        rx_lr  = lr0;
      end else begin
        rx_pos++;
      end
      if (rx_pos >= 1 && rx_pos <= SIG) begin
        rx_sh = {rx_sh[14:0], sd0};
        if (rx_pos == SIG) rx_q.push_back({rx_lr, rx_sh});
      end else if (rx_pos > SIG && sd0) begin
        rx_tail++;
      end
    end
  end

  task automatic wait_stb0(input int sz, input int budget);
    int i = 0;
    while (stb_t0.size() < sz && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("stb_wait", (stb_t0.size() >= sz) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Never let enable fall on the clk that closes a frame of either instance.
  task automatic drop_enable();
    int i = 0;
    while (((act[0] && n[0] == flen(0) - 1) || (act[1] && n[1] == flen(1) - 1)) && i < 4) begin
      @(negedge clk);
      i++;
    end
    enable = 1'b0;
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, s, i, nstb, bad_len, hold_cycles;
    logic [16:0] exp_words[6];
    exp_words = '{{1'b0, 16'hA5C3}, {1'b1, 16'hA5C3}, {1'b0, 16'h8001},
                  {1'b1, 16'h8001}, {1'b0, 16'h7FFF}, {1'b1, 16'h7FFF}};

    din = 16'hA5C3;
    repeat (3) @(negedge clk);
    chk("reset_state", {22'd0, stb0, bclk0, lr0, sd0, busy0, stb1, bclk1, lr1, sd1, busy1}, 32'd0);

    // Frame timing and bit capture with in changing mid-frame.
    rel     = cyc;
    reset_n = 1'b1;
    enable  = 1'b1;
    rx_on   = 1'b1;
    repeat (100) @(negedge clk);
    din = 16'h8001;
    wait_stb0(2, 1100);
    repeat (10 * 16 + 4) @(negedge clk);
    din = 16'h7FFF;
    wait_stb0(4, 2200);
    rx_on = 1'b0;

    chk("stb_entry", stb_t0[0], rel + 1);
    chk("stb_entry1", stb_t1[0], rel + 1);
    chk("frame_len0", stb_t0[1] - stb_t0[0], 1024);
    chk("frame_len1", stb_t1[1] - stb_t1[0], 136);
    chk("bclk_period", brise0[1] - brise0[0], 16);
    chk("rx_count", (rx_q.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    for (int j = 0; j < 6 && j < rx_q.size(); j++) chk("rx_word", rx_q[j], exp_words[j]);
    chk("rx_tail_zero", rx_tail, 0);
    bad_len = 0;
    foreach (slot_len[j]) if (slot_len[j] != 32) bad_len++;
    chk("slot_len", bad_len, 0);

    // Stop requested at bit 10: frame must complete, then stay parked.
    s = stb_t0[$];
    repeat (10 * 16 + 3) @(negedge clk);
    drop_enable();
    nstb = stb_t0.size();
    i = 0;
    while (busy0 && i < 1200) begin
      @(negedge clk);
      i++;
    end
    chk("stop_cycle", cyc - s, 1024);
    repeat (60) @(negedge clk);
    chk("idle_no_stb", stb_t0.size(), nstb);
    chk("idle_outs", {28'd0, bclk0, lr0, sd0, busy0}, 32'd0);

    // Restart, then a stop withdrawn mid-frame must not disturb the cadence.
    din    = 16'h1234;
    enable = 1'b1;
    wait_stb0(nstb + 1, 10);
    s = stb_t0[$];
    repeat (20 * 16) @(negedge clk);
    drop_enable();
    repeat (20 * 16) @(negedge clk);
    enable = 1'b1;
    wait_stb0(nstb + 2, 1100);
    chk("resume_len", stb_t0[$] - s, 1024);

    // Asynchronous reset in the right slot.
    repeat (40 * 16 + 3) @(negedge clk);
    chk("pre_rst_lr", lr0, 1'b1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst", {22'd0, stb0, bclk0, lr0, sd0, busy0, stb1, bclk1, lr1, sd1, busy1}, 32'd0);
    repeat (2) @(negedge clk);
    din     = 16'hC0DE;
    reset_n = 1'b1;
    @(negedge clk);
    chk("stb_after_rst", {30'd0, stb0, busy0}, 32'd3);

    // Random data and run/stop requests.
    for (int it = 0; it < 20; it++) begin
      hold_cycles = $urandom_range(50, 1500);
      repeat (hold_cycles) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) din = 16'($urandom);
      end
      if (enable) drop_enable();
      else enable = 1'b1;
    end
    enable = 1'b1;
    repeat (1100) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
